mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between two requesters: the instruction-fetch path (FETCH states) and the data path (loads/stores).
- Replaces the fixed wait states in the main control FSM with a req/gnt/rvalid handshake.
- Sits between the control/datapath and the memory model.
- Memory reads have a fixed latency of MEM_LAT cycles. Memory writes complete in one cycle.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 3, read latency in cycles; address held for MEM_LAT cycles, legal range >= 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
if_req  in  1  fetch read request
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted, 1-cycle pulse
if_rvalid  out  1  fetch read data valid, 1-cycle pulse
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data request
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data request accepted, 1-cycle pulse
d_rvalid  out  1  data read valid, 1-cycle pulse (reads only)
d_rdata  out  DATA_W  data read data
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write enable
mem_rdata  in  DATA_W  memory read data
busy  out  1  arbiter not IDLE

Behaviour:
- Reset (async): state IDLE, lat_cnt 0, last_d 1.
  - All outputs 0, including the mem_addr/mem_wdata registers and the shared rdata register.
- States:
  - IDLE: arbitrate on each edge. If any request is present, latch the winner's addr/we/wdata and the owner ID, set lat_cnt = 1, and go to ACC.
  - ACC: one cycle. Owner's gnt = 1. mem_addr/mem_wdata show the latched values. mem_we = latched we.
    - Write: go to IDLE.
    - Read with MEM_LAT = 1: capture mem_rdata at this edge and go to RESP.
    - Read with MEM_LAT > 1: go to WAIT.
  - WAIT: lat_cnt increments each edge. When lat_cnt == MEM_LAT at the edge, capture mem_rdata and go to RESP. The address is held for exactly MEM_LAT cycles, ACC included.
  - RESP: one cycle. Owner's rvalid = 1. Go to IDLE; no arbitration in RESP.
- Arbitration:
  - Two-way round-robin using flag last_d (1 = data was served last).
  - A sole requester always wins.
  - On a tie, fetch wins if last_d = 1, otherwise data wins.
  - last_d is updated on every grant.
- Latency:
  - Read: request sampled at edge E0 → gnt in cycle 1 → rvalid in cycle MEM_LAT+1.
  - Write: gnt and mem_we in cycle 1 only.
- Handshake rules:
  - Requester must hold req and its operands stable until the sampling edge.
  - Requester must drop req in its gnt cycle. If req is still high when the arbiter is next in IDLE, it is a new request.
  - Requests arriving while busy are ignored until IDLE (no queueing).
- Outputs:
  - mem_we is high only in ACC of a write; 0 in all other states.
  - mem_addr/mem_wdata hold their last value when IDLE.
  - if_rdata and d_rdata both drive the one shared rdata register. It updates only on read capture, holds otherwise, and is qualified by rvalid.
  - busy = (state != IDLE).
- lat_cnt width: clog2(MEM_LAT+1).
- Reset mid-operation: the transaction is dropped immediately. No gnt, rvalid or mem_we follows. last_d returns to 1.

Decomposition:
- Shared include/package mem_arb_pkg:
  - state encodings IDLE/ACC/WAIT/RESP
  - owner IDs OWN_IF = 0, OWN_D = 1
- One sub-module, rr_arb2: combinational two-way round-robin pick.
  - Inputs: req0, req1, last.
  - Outputs: gnt_valid, sel.
  - Instantiated once in IDLE.

Test Plan:
- Reset: assert rst mid-cycle → all outputs 0 and busy 0 immediately, asynchronously. Release → IDLE.
- Fetch read, MEM_LAT = 3, if_addr = 0x00000004, memory returns 0xDEADBEEF:
  - if_gnt in cycle 1; mem_addr = 0x4 in cycles 1–3.
  - if_rvalid in cycle 4 with if_rdata = 0xDEADBEEF.
  - d_gnt and d_rvalid stay 0.
- Data write, d_addr = 0x10, d_wdata = 0x1234:
  - mem_we = 1 for exactly one cycle with mem_addr = 0x10 and mem_wdata = 0x1234; d_gnt in the same cycle.
  - No rvalid; busy drops the next cycle.
- if_req and d_req held high together from reset, each dropped in its gnt cycle and re-raised → grants alternate F, D, F, D. No back-to-back grants to the same port.
- rst pulse during WAIT of a data read → IDLE next, d_rvalid never asserts, rdata = 0. A following fetch request wins.
- MEM_LAT = 1 build, d_addr = 0x20 read → d_gnt in cycle 1, d_rvalid in cycle 2; WAIT is never entered.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encodings and owner IDs for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } arb_state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic gnt_valid,
   output logic sel
);

   // sel = 1 picks req1; on a tie req1 wins only when req0's side was served last
   assign gnt_valid = req0 | req1;
   assign sel       = req1 & (~req0 | ~last);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int               LAT_W   = $clog2(MEM_LAT + 1);
   localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MEM_LAT);
   localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

   arb_state_t        state_q;
   arb_state_t        state_d;
   logic [LAT_W-1:0]  lat_cnt;
   logic              last_d;
   logic              owner_q;
   logic              we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              arb_valid;
   logic              arb_sel;

   rr_arb2 u_arb (
      .req0      (if_req),
      .req1      (d_req),
      .last      (last_d),
      .gnt_valid (arb_valid),
      .sel       (arb_sel)
   );

   // State register; reset drops any transaction in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: arbitrate only in IDLE, walk ACC -> WAIT -> RESP for reads
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               state_d = ACC;
            end
         end
         ACC: begin
            if (we_q) begin
               state_d = IDLE;
            end else if (MEM_LAT == 1) begin
               state_d = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt == LAT_MAX) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Latch the winner's operands, count read latency and capture read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_cnt     <= '0;
         last_d      <= 1'b1;
         owner_q     <= OWN_IF;
         we_q        <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  owner_q <= arb_sel;
                  last_d  <= arb_sel;
                  lat_cnt <= LAT_ONE;
                  if (arb_sel == OWN_D) begin
                     mem_addr_q  <= d_addr;
                     mem_wdata_q <= d_wdata;
                     we_q        <= d_we;
                  end else begin
                     mem_addr_q <= if_addr;
                     we_q       <= 1'b0;
                  end
               end
            end
            ACC: begin
               if (!we_q) begin
                  if (MEM_LAT == 1) begin
                     rdata_q <= mem_rdata;
                  end else begin
                     lat_cnt <= lat_cnt + LAT_ONE;
                  end
               end
            end
            WAIT: begin
               if (lat_cnt == LAT_MAX) begin
                  rdata_q <= mem_rdata;
               end else begin
                  lat_cnt <= lat_cnt + LAT_ONE;
               end
            end
            RESP: begin
               lat_cnt <= '0;
            end
            default: begin
               lat_cnt <= '0;
            end
         endcase
      end
   end

   // Handshake strobes decoded from state and owner
   always_comb begin
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      mem_we    = 1'b0;
      case (state_q)
         ACC: begin
            if_gnt = (owner_q == OWN_IF);
            d_gnt  = (owner_q == OWN_D);
            mem_we = we_q;
         end
         RESP: begin
            if_rvalid = (owner_q == OWN_IF);
            d_rvalid  = (owner_q == OWN_D);
         end
         default: begin
            mem_we = 1'b0;
         end
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = rdata_q;
   assign d_rdata   = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int LAT = 3;

   logic        clk, rst;
   logic        if_req, if_gnt, if_rvalid;
   logic [31:0] if_addr, if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, busy;

   logic        if_req1, if_gnt1, if_rvalid1;
   logic [31:0] if_addr1, if_rdata1;
   logic        d_req1, d_we1, d_gnt1, d_rvalid1;
   logic [31:0] d_addr1, d_wdata1, d_rdata1;
   logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;
   logic        mem_we1, busy1;

   int n_assert = 0;
   int n_fail   = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst),
      .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
      .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
      .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_we(mem_we1), .mem_rdata(mem_rdata1),
      .busy(busy1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] init_val(input int i);
      return (i == 1) ? 32'hDEADBEEF : 32'h9E37_79B9 * 32'(i + 1);
   endfunction

   // Memory with MEM_LAT read latency: data is only valid in the last cycle of the address hold
   logic [31:0] wr_mem [0:63];
   bit   [63:0] wr_valid;
   logic [3:0]  age_q, age;
   logic [5:0]  midx;

   always @(posedge clk) begin
      if (!rst && mem_we) begin
         wr_mem[mem_addr[7:2]]   <= mem_wdata;
         wr_valid[mem_addr[7:2]] <= 1'b1;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) age_q <= 4'd0;
      else     age_q <= (age != 4'd0 && age < 4'(LAT)) ? age + 4'd1 : 4'd0;
   end

   always_comb begin
      midx      = mem_addr[7:2];
      age       = ((if_gnt || d_gnt) && !mem_we) ? 4'd1 : age_q;
      mem_rdata = 32'hBAD0_BAD0;
      if (age == 4'(LAT))
         mem_rdata = wr_valid[midx] ? wr_mem[midx] : init_val(int'(midx));
   end

   assign mem_rdata1 = (d_gnt1 && !mem_we1) ? (mem_addr1 ^ 32'hC0DE_0000) : 32'hBAD0_BAD0;

   logic [31:0] ref_mem [0:63];
   bit          last_d_m;

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One full transaction for owner own (0 fetch, 1 data), starting in an IDLE cycle
   task automatic serve(input bit own, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      @(posedge clk); #1;
      chk1(own ? "d_gnt" : "if_gnt", own ? d_gnt : if_gnt, 1'b1);
      chk1("other_gnt", own ? if_gnt : d_gnt, 1'b0);
      chk32("mem_addr_c1", mem_addr, addr);
      chk1("mem_we_c1", mem_we, we);
      if (we) chk32("mem_wdata", mem_wdata, wdata);
      chk1("busy_c1", busy, 1'b1);
      if (own) d_req = 1'b0;
      else     if_req = 1'b0;
      last_d_m = own;
      if (we) ref_mem[addr[7:2]] = wdata;
      if (!we) begin
         for (int c = 2; c <= LAT; c++) begin
            @(posedge clk); #1;
            chk32("mem_addr_hold", mem_addr, addr);
            chk1("mem_we_wait", mem_we, 1'b0);
            chk32("strobes_wait", {28'd0, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'd0);
         end
         @(posedge clk); #1;
         chk1(own ? "d_rvalid" : "if_rvalid", own ? d_rvalid : if_rvalid, 1'b1);
         chk1("other_rvalid", own ? if_rvalid : d_rvalid, 1'b0);
         chk32(own ? "d_rdata" : "if_rdata", own ? d_rdata : if_rdata, ref_mem[addr[7:2]]);
         chk1("gnt_resp", if_gnt | d_gnt, 1'b0);
      end
      @(posedge clk); #1;
      chk1("busy_after", busy, 1'b0);
      chk32("strobes_after", {27'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we}, 32'd0);
   endtask

   bit          fe, de, dw, w;
   logic [31:0] fa, da, dwd;

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
      last_d_m = 1'b1;
      rst = 1'b1;
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      if_req1 = 0; if_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;

      // Reset state
      #2;
      chk32("rst_outs", {27'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we}, 32'd0);
      chk1("rst_busy", busy, 1'b0);
      chk32("rst_mem_addr", mem_addr, 32'd0);
      chk32("rst_mem_wdata", mem_wdata, 32'd0);
      chk32("rst_rdata", if_rdata | d_rdata, 32'd0);
      chk1("rst_busy1", busy1, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk1("idle_busy", busy, 1'b0);

      // Fetch read of address 4 returning DEADBEEF
      if_req = 1'b1; if_addr = 32'h4;
      serve(1'b0, 1'b0, 32'h4, 32'd0);
      chk32("fetch_deadbeef", if_rdata, 32'hDEADBEEF);

      // Data write 0x1234 to 0x10
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h1234;
      serve(1'b1, 1'b1, 32'h10, 32'h1234);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
      serve(1'b1, 1'b0, 32'h10, 32'd0);

      // MEM_LAT = 1 instance: gnt in cycle 1, rvalid in cycle 2, idle in cycle 3
      for (int k = 0; k < 3; k++) begin
         d_addr1 = (k == 0) ? 32'h20 : ($urandom_range(0, 63) << 2);
         d_req1 = 1'b1; d_we1 = 1'b0;
         @(posedge clk); #1;
         chk1("l1_gnt", d_gnt1, 1'b1);
         chk32("l1_mem_addr", mem_addr1, d_addr1);
         d_req1 = 1'b0;
         @(posedge clk); #1;
         chk1("l1_rvalid", d_rvalid1, 1'b1);
         chk32("l1_rdata", d_rdata1, d_addr1 ^ 32'hC0DE_0000);
         @(posedge clk); #1;
         chk1("l1_busy_after", busy1, 1'b0);
         chk1("l1_rvalid_after", d_rvalid1, 1'b0);
      end

      // Both requesters held from reset: grants alternate F, D, F, D
      rst = 1'b1; #2; rst = 1'b0;
      last_d_m = 1'b1;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h8;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
      for (int k = 0; k < 4; k++) begin
         w = k[0];
         serve(w, 1'b0, w ? d_addr : if_addr, 32'd0);
         if (w) d_req = 1'b1;
         else   if_req = 1'b1;
      end
      if_req = 1'b0; d_req = 1'b0;

      // Randomized mix checked against the round-robin rule
      for (int it = 0; it < 24; it++) begin
         fe  = 1'($urandom_range(0, 1));
         de  = 1'($urandom_range(0, 1));
         if (!fe && !de) fe = 1'b1;
         fa  = $urandom_range(0, 63) << 2;
         da  = $urandom_range(0, 63) << 2;
         dw  = 1'($urandom_range(0, 1));
         dwd = $urandom;
         if_req = fe; if_addr = fa;
         d_req = de; d_we = dw; d_addr = da; d_wdata = dwd;
         if (fe && de) begin
            w = last_d_m ? 1'b0 : 1'b1;
            if (w) begin
               serve(1'b1, dw, da, dwd);
               serve(1'b0, 1'b0, fa, 32'd0);
            end else begin
               serve(1'b0, 1'b0, fa, 32'd0);
               serve(1'b1, dw, da, dwd);
            end
         end else if (de) begin
            serve(1'b1, dw, da, dwd);
         end else begin
            serve(1'b0, 1'b0, fa, 32'd0);
         end
      end

      // Reset pulse during WAIT of a data read
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      @(posedge clk); #1;
      chk1("rw_gnt", d_gnt, 1'b1);
      d_req = 1'b0;
      @(posedge clk); #1;
      chk1("rw_busy_wait", busy, 1'b1);
      #3 rst = 1'b1;
      #1;
      chk1("rw_async_busy", busy, 1'b0);
      chk32("rw_async_outs", {27'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we}, 32'd0);
      chk32("rw_async_addr", mem_addr, 32'd0);
      chk32("rw_async_wdata", mem_wdata, 32'd0);
      chk32("rw_async_rdata", d_rdata, 32'd0);
      #1 rst = 1'b0;
      last_d_m = 1'b1;
      for (int k = 0; k < LAT + 2; k++) begin
         @(posedge clk); #1;
         chk1("rw_no_rvalid", d_rvalid, 1'b0);
         chk1("rw_idle", busy, 1'b0);
         chk32("rw_rdata_zero", d_rdata, 32'd0);
      end
      if_req = 1'b1; if_addr = 32'h4;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
      serve(1'b0, 1'b0, 32'h4, 32'd0);
      serve(1'b1, 1'b0, 32'h10, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
